// File: rtl/uart_boot_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_boot_loader: pairs UART bytes into 16-bit words and writes a length- |
// | prefixed program image into instruction memory while holding the CPU.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_boot_loader #(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_over,
  input  logic [7:0]        rx_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int          CW       = ADDR_W + 1;
  localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MAX_LEN  = 17'(2 ** ADDR_W);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN_L = 3'd1;
  localparam logic [2:0] S_LEN_H = 3'd2;
  localparam logic [2:0] S_DAT_L = 3'd3;
  localparam logic [2:0] S_DAT_H = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [2:0]        sync_q, sync_d;
  logic [7:0]        byte_q, byte_d;
  logic              pending_q, pending_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        wlo_q, wlo_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]     word_count_q, word_count_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;

  logic        ev;
  logic        in_rx;
  logic        pend_clr;
  logic        tmo;
  logic [15:0] full_len;

  always_comb begin
    // rx_over is asynchronous: two sync stages, third stage for edge detect
    sync_d       = {sync_q[1:0], rx_over};
    ev           = sync_q[1] & ~sync_q[2];
    byte_d       = ev ? rx_byte : byte_q;
    state_d      = state_q;
    len_d        = len_q;
    wlo_d        = wlo_q;
    ptr_d        = ptr_q;
    word_count_d = word_count_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pend_clr     = 1'b0;
    full_len     = {byte_q, len_q[7:0]};
    in_rx        = (state_q == S_LEN_L) || (state_q == S_LEN_H) ||
                   (state_q == S_DAT_L) || (state_q == S_DAT_H);

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_LEN_L;
          ptr_d        = '0;
          word_count_d = '0;
          pend_clr     = 1'b1;
        end
      end
      S_LEN_L: begin
        if (pending_q) begin
          len_d[7:0] = byte_q;
          pend_clr   = 1'b1;
          state_d    = S_LEN_H;
        end
      end
      S_LEN_H: begin
        if (pending_q) begin
          len_d    = full_len;
          pend_clr = 1'b1;
          if (full_len == 16'd0)                state_d = S_DONE;
          else if ({1'b0, full_len} > MAX_LEN)  state_d = S_ERR;
          else                                  state_d = S_DAT_L;
        end
      end
      S_DAT_L: begin
        if (pending_q) begin
          wlo_d    = byte_q;
          pend_clr = 1'b1;
          state_d  = S_DAT_H;
        end
      end
      S_DAT_H: begin
        if (pending_q) begin
          mem_addr_d  = ptr_q;
          mem_wdata_d = {byte_q, wlo_q};
          pend_clr    = 1'b1;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        ptr_d        = ptr_q + ADDR_W'(1);
        word_count_d = word_count_q + CW'(1);
        if (17'(word_count_q) + 17'd1 == {1'b0, len_q}) state_d = S_DONE;
        else                                             state_d = S_DAT_L;
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timer only advances while waiting for a byte
    tmr_d = '0;
    tmo   = 1'b0;
    if (in_rx && !ev && !pending_q) begin
      if (tmr_q == TMR_LAST) tmo = 1'b1;
      else                   tmr_d = tmr_q + TW'(1);
    end

    if (tmo)             state_d = S_ERR;
    if (ev && pending_q) state_d = S_ERR;

    pending_d = ev | (pending_q & ~pend_clr);
    mem_we_d  = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      byte_q       <= '0;
      pending_q    <= 1'b0;
      len_q        <= '0;
      wlo_q        <= '0;
      ptr_q        <= '0;
      word_count_q <= '0;
      tmr_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      byte_q       <= byte_d;
      pending_q    <= pending_d;
      len_q        <= len_d;
      wlo_q        <= wlo_d;
      ptr_q        <= ptr_d;
      word_count_q <= word_count_d;
      tmr_q        <= tmr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign busy       = (state_q >= S_LEN_L) && (state_q <= S_WRITE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign cpu_hold   = busy | err;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_boot_loader: directed and randomized image loads checked against |
// | a word-list model of the image format.  Revision: 1.0                    |
// +--------------------------------------------------------------------------+
module tb_uart_boot_loader;

  localparam int AW   = 4;
  localparam int TMO  = 100;
  localparam int MAXW = 1 << AW;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst_n, start, rx_over;
  logic [7:0]    rx_byte;
  logic          mem_we, cpu_hold, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [AW:0]   word_count;

  int checks   = 0;
  int failures = 0;
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  uart_boot_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_over(rx_over), .rx_byte(rx_byte),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always @(negedge clk)
    if (mem_we === 1'b1) got_q.push_back({12'd0, mem_addr, mem_wdata});

  initial begin
    #2ms;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_byte = b; rx_over = 1'b1;
    repeat (3) @(negedge clk);
    rx_over = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check({tag, ".idle_bound"}, 32'(n < 2000), 32'd1);
  endtask

  function automatic bq_t mk_img(input int len);
    bq_t q;
    q.push_back(8'(len));
    q.push_back(8'(len >> 8));
    for (int i = 0; i < 2 * len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Model: header word = count; count>MAX_WORDS aborts; else word i -> address i
  task automatic expect_result(input string tag, input bq_t img);
    int len, n;
    bit e;
    logic [15:0] d;
    len = int'(img[0]) + 256 * int'(img[1]);
    e   = len > MAXW;
    n   = e ? 0 : len;
    check({tag, ".done"},     32'(done),       32'(!e));
    check({tag, ".err"},      32'(err),        32'(e));
    check({tag, ".cpu_hold"}, 32'(cpu_hold),   32'(e));
    check({tag, ".busy"},     32'(busy),       32'd0);
    check({tag, ".wcount"},   32'(word_count), 32'(n));
    check({tag, ".nwrites"},  32'(got_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      d = 16'(img[2 + 2 * i]) | (16'(img[3 + 2 * i]) << 8);
      if (i < got_q.size())
        check($sformatf("%s.wr%0d", tag, i), got_q[i], {12'd0, 4'(i), d});
      if (i == n - 1) begin
        check({tag, ".addr_hold"},  32'(mem_addr),  32'(i));
        check({tag, ".wdata_hold"}, 32'(mem_wdata), 32'(d));
      end
    end
  endtask

  task automatic run_load(input string tag, input bq_t img);
    got_q.delete();
    pulse_start();
    check({tag, ".busy_on"}, 32'(busy), 32'd1);
    check({tag, ".hold_on"}, 32'(cpu_hold), 32'd1);
    check({tag, ".done_clr"}, 32'(done), 32'd0);
    foreach (img[i]) send_byte(img[i]);
    wait_idle(tag);
    expect_result(tag, img);
  endtask

  initial begin
    bq_t img;
    int n;
    rst_n = 1'b0; start = 1'b0; rx_over = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 0);        check("rst.done", 32'(done), 0);
    check("rst.err", 32'(err), 0);          check("rst.hold", 32'(cpu_hold), 0);
    check("rst.we", 32'(mem_we), 0);        check("rst.addr", 32'(mem_addr), 0);
    check("rst.wdata", 32'(mem_wdata), 0);  check("rst.wcount", 32'(word_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    img = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    run_load("t1", img);
    check("t1.word0", got_q[0], 32'h0000_1234);
    img = {8'h00, 8'h00};
    run_load("t2_empty", img);
    img = {8'h11, 8'h00};
    run_load("t3_toolong", img);
    img = mk_img(MAXW);
    run_load("max_len", img);

    // Timeout: error 100 clk after the last byte is consumed (4 clk after rx_over rises)
    got_q.delete();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    @(negedge clk); rx_byte = 8'hAA; rx_over = 1'b1;
    repeat (4) @(negedge clk);
    rx_over = 1'b0;
    repeat (99) @(negedge clk);
    check("t4.err_early", 32'(err), 32'd0);
    check("t4.busy_early", 32'(busy), 32'd1);
    @(negedge clk);
    check("t4.err", 32'(err), 32'd1);
    check("t4.hold", 32'(cpu_hold), 32'd1);
    check("t4.nwrites", 32'(got_q.size()), 32'd0);
    img = {8'h01, 8'h00, 8'hCD, 8'hAB};
    run_load("t4_retry", img);

    // Reset while the second word's write strobe is high
    got_q.delete();
    pulse_start();
    img = {8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
    foreach (img[i]) send_byte(img[i]);
    check("t5.wcount1", 32'(word_count), 32'd1);
    @(negedge clk); rx_byte = 8'h44; rx_over = 1'b1;
    n = 0;
    while (mem_we !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("t5.we_seen", 32'(mem_we), 32'd1);
    check("t5.addr1", 32'(mem_addr), 32'd1);
    check("t5.data1", 32'(mem_wdata), 32'h4433);
    rst_n = 1'b0;
    #1;
    check("t5.we", 32'(mem_we), 0);       check("t5.busy", 32'(busy), 0);
    check("t5.hold", 32'(cpu_hold), 0);   check("t5.addr", 32'(mem_addr), 0);
    check("t5.wdata", 32'(mem_wdata), 0); check("t5.wcount", 32'(word_count), 0);
    rx_over = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    img = mk_img(3);
    run_load("t5_reload", img);

    // start ignored mid-load; a long rx_over level is one byte
    got_q.delete();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    pulse_start();
    send_byte(8'h11); send_byte(8'h22);
    pulse_start();
    check("t6.busy", 32'(busy), 32'd1);
    check("t6.wcount", 32'(word_count), 32'd1);
    @(negedge clk); rx_byte = 8'h33; rx_over = 1'b1;
    repeat (50) @(negedge clk);
    rx_over = 1'b0;
    repeat (5) @(negedge clk);
    send_byte(8'h44);
    wait_idle("t6");
    img = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    expect_result("t6", img);

    // Two byte events with nothing consuming in between
    got_q.delete();
    send_byte(8'h55); send_byte(8'h66);
    check("t6.ovr_err", 32'(err), 32'd1);
    check("t6.ovr_done", 32'(done), 32'd0);
    check("t6.ovr_hold", 32'(cpu_hold), 32'd1);

    for (int k = 0; k < 3; k++) begin
      img = mk_img(int'($urandom_range(1, MAXW)));
      run_load($sformatf("rnd%0d", k), img);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
